// File: rtl/pcie_bar_csr_if.sv
// Avalon-MM slave bus bundle for the BAR0 CSR block.
// The master modport is the HIP Rx master side. The slave modport is the register block side.
interface pcie_bar_csr_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/pcie_bar_csr.sv
// BAR0 register block behind the Cyclone V PCIe HIP Rx master.
// It holds ID, scratch, control/status, a doorbell, an interval timer and access counters.
// It drives a level interrupt toward RxmIrq[0].
module pcie_bar_csr #(
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] ID_VALUE = 32'h5043_4956
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    pcie_bar_csr_if.slave          avs,
    output logic                   irq_out
);
    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_DOORBEL = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_DB_DATA = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_TLOAD   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_TCOUNT  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_ACCESS  = ADDR_W'(8);

    // Register state
    logic        wait_reg;
    logic [31:0] scratch_reg, scratch_next;
    logic [2:0]  ctrl_reg, ctrl_next;
    logic [1:0]  status_reg, status_next;
    logic [7:0]  db_data_reg, db_data_next;
    logic [31:0] load_reg, load_next;
    logic [31:0] count_reg, count_next;
    logic [15:0] rd_cnt_reg, wr_cnt_reg;
    logic        irq_reg, irq_next;

    // Read pipeline: the sample stage, a delay stage, then the output stage
    logic        s1_valid_reg, s2_valid_reg, rvalid_reg;
    logic [31:0] s1_data_reg, s2_data_reg, rdata_reg;

    // Decoded strobes
    logic        rd_acc, wr_acc;
    logic        wr_scratch, wr_ctrl, wr_status, wr_db, wr_load;
    logic [31:0] be_mask;
    logic [31:0] rd_mux;
    logic        timer_en, timer_zero;
    logic [1:0]  status_set, status_clr;

    assign rd_acc     = avs.read  & ~wait_reg;
    assign wr_acc     = avs.write & ~wait_reg;
    assign wr_scratch = wr_acc && (avs.address == A_SCRATCH);
    assign wr_ctrl    = wr_acc && (avs.address == A_CTRL);
    assign wr_status  = wr_acc && (avs.address == A_STATUS);
    assign wr_db      = wr_acc && (avs.address == A_DOORBEL);
    assign wr_load    = wr_acc && (avs.address == A_TLOAD);

    assign timer_en   = ctrl_reg[0];
    assign timer_zero = (count_reg == 32'd0);

    // Expand byte enables into a bit mask for the byte-enabled RW registers
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign be_mask[8*gi +: 8] = {8{avs.byteenable[gi]}};
        end
    endgenerate

    // Next-state logic for all software- and hardware-updated registers
    always_comb begin
        scratch_next = scratch_reg;
        ctrl_next    = ctrl_reg;
        db_data_next = db_data_reg;
        load_next    = load_reg;
        count_next   = count_reg;
        status_set   = 2'b00;
        status_clr   = 2'b00;

        if (wr_scratch)
            scratch_next = (scratch_reg & ~be_mask) | (avs.writedata & be_mask);
        // Only bits [2:0] exist, so only byte lane 0 can change CTRL
        if (wr_ctrl && avs.byteenable[0])
            ctrl_next = avs.writedata[2:0];
        if (wr_db && avs.byteenable[0]) begin
            db_data_next  = avs.writedata[7:0];
            status_set[0] = 1'b1;
        end
        if (wr_status && avs.byteenable[0])
            status_clr = avs.writedata[1:0];

        // The timer counts down and reloads on zero. A software load overrides both.
        if (timer_en) begin
            if (timer_zero) begin
                count_next    = load_reg;
                status_set[1] = 1'b1;
            end else begin
                count_next = count_reg - 32'd1;
            end
        end
        if (wr_load) begin
            load_next  = (load_reg & ~be_mask) | (avs.writedata & be_mask);
            count_next = load_next;
        end

        // A hardware set beats a software clear in the same cycle
        status_next = (status_reg & ~status_clr) | status_set;
        irq_next    = ctrl_reg[1] & (status_reg[0] | (status_reg[1] & ctrl_reg[2]));
    end

    // Read data mux, sampled at the accepting edge so that a read sees the pre-write value
    always_comb begin
        rd_mux = 32'd0;
        case (avs.address)
            A_ID:      rd_mux = ID_VALUE;
            A_SCRATCH: rd_mux = scratch_reg;
            A_CTRL:    rd_mux = {29'd0, ctrl_reg};
            A_STATUS:  rd_mux = {30'd0, status_reg};
            A_DB_DATA: rd_mux = {24'd0, db_data_reg};
            A_TLOAD:   rd_mux = load_reg;
            A_TCOUNT:  rd_mux = count_reg;
            A_ACCESS:  rd_mux = {wr_cnt_reg, rd_cnt_reg};
            default:   rd_mux = 32'd0;
        endcase
    end

    // Register file, counters and interrupt register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wait_reg    <= 1'b1;
            scratch_reg <= 32'd0;
            ctrl_reg    <= 3'd0;
            status_reg  <= 2'd0;
            db_data_reg <= 8'd0;
            load_reg    <= 32'd0;
            count_reg   <= 32'd0;
            rd_cnt_reg  <= 16'd0;
            wr_cnt_reg  <= 16'd0;
            irq_reg     <= 1'b0;
        end else begin
            wait_reg    <= 1'b0;
            scratch_reg <= scratch_next;
            ctrl_reg    <= ctrl_next;
            status_reg  <= status_next;
            db_data_reg <= db_data_next;
            load_reg    <= load_next;
            count_reg   <= count_next;
            rd_cnt_reg  <= rd_cnt_reg + {15'd0, rd_acc};
            wr_cnt_reg  <= wr_cnt_reg + {15'd0, wr_acc};
            irq_reg     <= irq_next;
        end
    end

    // Read response pipeline. Reset drops any read that is still in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= 32'd0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= 32'd0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            s1_valid_reg <= rd_acc;
            s1_data_reg  <= rd_acc ? rd_mux : 32'd0;
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= s1_data_reg;
            rvalid_reg   <= s2_valid_reg;
            rdata_reg    <= s2_valid_reg ? s2_data_reg : 32'd0;
        end
    end

    assign avs.readdata      = rdata_reg;
    assign avs.readdatavalid = rvalid_reg;
    assign avs.waitrequest   = wait_reg;
    assign irq_out           = irq_reg;
endmodule

// File: tb/tb_pcie_bar_csr.sv
// Directed bench for pcie_bar_csr.
// A vector table covers single register accesses.
// Hand sequences cover the pipelined, interrupt, timer and reset corner cases.
module tb_pcie_bar_csr;
    localparam logic [31:0] ID = 32'h5043_4956;

    logic clk_clk;
    logic reset_reset_n;
    logic irq_out;

    pcie_bar_csr_if #(.ADDR_W(4)) bus ();

    pcie_bar_csr #(.ADDR_W(4), .ID_VALUE(ID)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs           (bus.slave),
        .irq_out       (irq_out)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        use_cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   rd_m  = 0;
    int   wr_m  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
        wr_m++;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.address = a; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        rd_m++;
        tick();
        check({name, "_early"}, {31'd0, bus.readdatavalid}, 32'd0);
        tick();
        check({name, "_valid"}, {31'd0, bus.readdatavalid}, 32'd1);
        check(name, bus.readdata, exp);
    endtask

    task automatic do_reset();
        idle_bus();
        reset_reset_n = 1'b0;
        repeat (3) tick();
        reset_reset_n = 1'b1;
        tick();
        rd_m = 0;
        wr_m = 0;
    endtask

    task automatic add(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] e, input logic uc);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.be = be; v.exp = e; v.use_cnt = uc;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        int          e_start;

        // Register-level vectors: {write?, addr, data, be, expected read, expect counters}
        add(0, 4'h0, 0, 0, ID, 0);
        add(1, 4'h1, 32'h1122_3344, 4'hF, 0, 0);
        add(1, 4'h1, 32'hAABB_CCDD, 4'h5, 0, 0);
        add(0, 4'h1, 0, 0, 32'h11BB_33DD, 0);
        add(1, 4'h2, 32'hFFFF_FFF8, 4'hF, 0, 0);
        add(0, 4'h2, 0, 0, 32'h0, 0);
        add(1, 4'h2, 32'h0000_0006, 4'hE, 0, 0);
        add(0, 4'h2, 0, 0, 32'h0, 0);
        add(1, 4'h9, 32'h0000_1234, 4'hF, 0, 0);
        add(0, 4'h9, 0, 0, 32'h0, 0);
        add(1, 4'h0, 32'h0000_DEAD, 4'hF, 0, 0);
        add(0, 4'h0, 0, 0, ID, 0);
        add(1, 4'h4, 32'h0000_0077, 4'hE, 0, 0);
        add(0, 4'h3, 0, 0, 32'h0, 0);
        add(0, 4'h5, 0, 0, 32'h0, 0);
        add(1, 4'h6, 32'h0000_0100, 4'h3, 0, 0);
        add(0, 4'h6, 0, 0, 32'h0000_0100, 0);
        add(0, 4'h7, 0, 0, 32'h0000_0100, 0);
        add(1, 4'h6, 32'hFFFF_FFFF, 4'h4, 0, 0);
        add(0, 4'h6, 0, 0, 32'h00FF_0100, 0);
        add(1, 4'h7, 32'h0000_0055, 4'hF, 0, 0);
        add(0, 4'h7, 0, 0, 32'h00FF_0100, 0);
        add(0, 4'h4, 0, 0, 32'h0, 0);
        add(0, 4'h8, 0, 0, 0, 1);

        // Reset values and waitrequest release
        idle_bus();
        reset_reset_n = 1'b0;
        repeat (3) tick();
        check("rst_wait", {31'd0, bus.waitrequest}, 32'd1);
        check("rst_rvalid", {31'd0, bus.readdatavalid}, 32'd0);
        check("rst_rdata", bus.readdata, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        reset_reset_n = 1'b1;
        #2;
        check("wait_after_release", {31'd0, bus.waitrequest}, 32'd1);
        tick();
        check("wait_first_edge", {31'd0, bus.waitrequest}, 32'd0);

        // Table-driven register accesses
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) begin
                bus_write(tbl[i].addr, tbl[i].data, tbl[i].be);
                $display("vec%0d write a=%h d=%h be=%h", i, tbl[i].addr, tbl[i].data, tbl[i].be);
            end else begin
                e = tbl[i].use_cnt ? {wr_m[15:0], rd_m[15:0]} : tbl[i].exp;
                bus_read($sformatf("vec%0d_rd_a%h", i, tbl[i].addr), tbl[i].addr, e);
            end
        end

        // Back-to-back reads: 0x0, 0x1, 0x8 on consecutive edges
        do_reset();
        bus.read = 1'b1; bus.address = 4'h0;
        tick();
        bus.address = 4'h1;
        tick();
        check("b2b_early", {31'd0, bus.readdatavalid}, 32'd0);
        bus.address = 4'h8;
        tick();
        bus.read = 1'b0;
        rd_m += 3;
        check("b2b_v0", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b_d0", bus.readdata, ID);
        tick();
        check("b2b_v1", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b_d1", bus.readdata, 32'd0);
        tick();
        check("b2b_v2", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b_d2", bus.readdata, 32'h0000_0002);
        tick();
        check("b2b_end_v", {31'd0, bus.readdatavalid}, 32'd0);
        check("b2b_end_d", bus.readdata, 32'd0);

        // Doorbell interrupt raise and W1C clear
        bus_write(4'h2, 32'h2, 4'hF);
        bus_write(4'h4, 32'h5A, 4'hF);
        check("db_irq_n1", {31'd0, irq_out}, 32'd0);
        tick();
        check("db_irq_n2", {31'd0, irq_out}, 32'd1);
        bus_read("db_data", 4'h5, 32'h5A);
        bus_read("db_status", 4'h3, 32'h1);
        bus_read("db_status_again", 4'h3, 32'h1);
        bus_write(4'h3, 32'h1, 4'h1);
        check("db_clr_n1", {31'd0, irq_out}, 32'd1);
        tick();
        check("db_clr_n2", {31'd0, irq_out}, 32'd0);

        // Timer: LOAD=3 gives a 4-cycle period; expiry sets at E+4, irq at E+5
        bus_write(4'h6, 32'h3, 4'hF);
        bus_write(4'h2, 32'h7, 4'hF);
        e_start = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("tmr_irq_e%0d", k), {31'd0, irq_out}, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        tick();
        // W1C of timer_expired lands on the E+8 expiry edge; the set must win
        bus.address = 4'h3; bus.writedata = 32'h2; bus.byteenable = 4'h1; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; wr_m++;
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0; rd_m++;
        tick();
        check("tmr_w1c_early", {31'd0, bus.readdatavalid}, 32'd0);
        tick();
        check("tmr_w1c_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("tmr_w1c_set_wins", bus.readdata, 32'h2);
        // Disabling at E+12 coincides with another expiry that reloads 3
        bus_write(4'h2, 32'h2, 4'hF);
        bus_write(4'h3, 32'h2, 4'h1);
        bus_read("tmr_status_clr", 4'h3, 32'h0);
        check("tmr_irq_off", {31'd0, irq_out}, 32'd0);
        bus_read("tmr_count_hold", 4'h7, 32'h3);
        // Load write beats the decrement; one more decrement before the disable lands
        bus_write(4'h2, 32'h1, 4'hF);
        bus_write(4'h6, 32'd10, 4'hF);
        bus_write(4'h2, 32'h0, 4'hF);
        bus_read("tmr_load_wins", 4'h7, 32'd9);
        bus_read("tmr_load_val", 4'h6, 32'd10);

        // Asynchronous reset while a read is in flight
        bus_write(4'h1, 32'hCAFE_F00D, 4'hF);
        bus_write(4'h2, 32'h2, 4'hF);
        bus_write(4'h4, 32'h1, 4'hF);
        tick();
        check("pre_rst_irq", {31'd0, irq_out}, 32'd1);
        bus.address = 4'h1; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("mid_rst_irq", {31'd0, irq_out}, 32'd0);
        check("mid_rst_wait", {31'd0, bus.waitrequest}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_rst_rvalid%0d", k), {31'd0, bus.readdatavalid}, 32'd0);
        end
        reset_reset_n = 1'b1;
        tick();
        rd_m = 0; wr_m = 0;
        check("post_rst_rvalid", {31'd0, bus.readdatavalid}, 32'd0);
        check("post_rst_irq", {31'd0, irq_out}, 32'd0);
        bus_read("post_rst_scratch", 4'h1, 32'h0);
        bus_read("post_rst_ctrl", 4'h2, 32'h0);
        bus_read("post_rst_status", 4'h3, 32'h0);
        bus_read("post_rst_dbdata", 4'h5, 32'h0);
        bus_read("post_rst_count", 4'h7, 32'h0);
        bus_read("post_rst_access", 4'h8, {wr_m[15:0], rd_m[15:0]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie_bar_csr.md
# pcie_bar_csr

Avalon-MM slave register block mapped behind BAR0 of the Cyclone V PCIe hard IP (Avalon-MM variant). It is instantiated inside the Qsys system on the HIP Rx master (Rxm_BAR0) path. The host sees an ID register, a scratch register, control/status registers, a host-to-FPGA doorbell and a programmable interval timer. The block drives the HIP's legacy interrupt input (RxmIrq) from doorbell and timer events.

## Interface
Parameters:
- ADDR_W, 4: word-address width; 16 decoded word slots.
- ID_VALUE, 32'h5043_4956: value returned by the ID register.

Ports:
- clk_clk  in  1  Avalon clock (HIP application clock domain); sole clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lanes for writes.
- avs_readdata  out  32  read data, valid with avs_readdatavalid.
- avs_readdatavalid  out  1  read response strobe.
- avs_waitrequest  out  1  slave stall.
- irq_out  out  1  level interrupt to RxmIrq[0].

## Operation
Register map (word address: name, access, reset value):
- 0x0: ID, RO, returns ID_VALUE.
- 0x1: SCRATCH, RW, 0. Byte-enabled write.
- 0x2: CTRL, RW, 0. Fields:
  - bit0 timer_en
  - bit1 irq_en
  - bit2 timer_irq_en
  - other bits read 0
- 0x3: STATUS, W1C, 0. Fields:
  - bit0 db_pending
  - bit1 timer_expired
  - A write of 1 with byteenable[0] clears the corresponding bit.
- 0x4: DOORBELL, WO, reads 0. A write with byteenable[0]=1 sets db_pending and latches writedata[7:0] into DB_DATA.
- 0x5: DB_DATA, RO, 0. Bits [7:0] hold the last doorbell byte.
- 0x6: TIMER_LOAD, RW, 0. Byte-enabled. Any write also copies the resulting value into TIMER_COUNT.
- 0x7: TIMER_COUNT, RO, 0.
- 0x8: ACCESS_CNT, RO, 0. Fields:
  - [15:0] serviced reads
  - [31:16] serviced writes
  - Both fields wrap modulo 2^16.
- 0x9 to 0xF: read 0; writes ignored.

Byteenable handling:
- Applies to the RW registers only.
- Disabled byte lanes keep their old value.

Timer:
- While timer_en=1, TIMER_COUNT decrements by 1 each cycle.
- In the cycle TIMER_COUNT==0 with timer_en=1: set timer_expired and reload TIMER_COUNT from TIMER_LOAD.
- The resulting period is TIMER_LOAD+1 cycles. LOAD=0 expires every cycle.
- timer_en=0 holds TIMER_COUNT at its current value.

Interrupt:
- irq_next = irq_en & (db_pending | (timer_expired & timer_irq_en)).
- irq_out is irq_next registered.
- irq_out is a level: it stays high until software clears the source, or clears irq_en.

Boundary rules:
- Hardware set and software W1C of the same STATUS bit in the same cycle: the set wins, and the bit stays 1.
- A TIMER_LOAD write in the same cycle as a timer reload or decrement: the write value wins.
- avs_read and avs_write in the same cycle (illegal on Avalon, but defined here):
  - Both are serviced.
  - The read returns the pre-write value.
  - Both counters increment.
- A read of STATUS does not clear it.
- Reset mid-transaction:
  - Any read in the pipeline is dropped, with no readdatavalid.
  - All state returns to reset values immediately (asynchronous).

## Timing
Reset values of outputs:
- avs_readdata = 0
- avs_readdatavalid = 0
- avs_waitrequest = 1
- irq_out = 0

Waitrequest:
- avs_waitrequest is 1 while reset_reset_n=0 and for the first clk_clk edge after deassertion.
- It is 0 thereafter. There is no other backpressure.

Writes:
- A write is accepted at clock edge N (waitrequest=0).
- The register value is visible from N+1.
- The resulting irq_out change appears at N+2.

Reads:
- Fixed latency of 2. A read accepted at edge N gives avs_readdatavalid=1 and avs_readdata for exactly one cycle after edge N+2.
- The register value is sampled at edge N, giving pre-write semantics.
- Back-to-back reads pipeline at one per cycle. Responses return in order.
- avs_readdata returns to 0 when avs_readdatavalid=0.

Timer and interrupt timing:
- timer_expired sets at the edge where TIMER_COUNT==0.
- irq_out follows timer_expired one edge later.

## Test plan
- Reset and ID: release reset, then read 0x0. Required: waitrequest=0 from the second edge after release; readdatavalid 2 cycles after the read with data 0x50434956; irq_out=0.
- Scratch and byteenable: write 0x11223344 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, then read. Required: read returns 0x11BB33DD.
- Back-to-back reads: issue reads of 0x0, 0x1, 0x8 on consecutive cycles. Required: three consecutive readdatavalid pulses in order; ACCESS_CNT[15:0] read value = 2, since the count is sampled pre-increment.
- Doorbell IRQ: write CTRL=0x2, then DOORBELL=0x5A. Required: irq_out rises 2 edges after the doorbell write and DB_DATA=0x5A. Then write STATUS=0x1. Required: irq_out falls 2 edges later.
- Timer: write TIMER_LOAD=3, then CTRL=0x7. Required: timer_expired sets 4 cycles after the enable takes effect and irq_out asserts. Then issue a W1C to STATUS in the same cycle as the next expiry. Required: the bit stays 1.
- Async reset mid-read: assert reset_reset_n=0 one cycle after a read is accepted. Required: no readdatavalid; irq_out and all registers read back as reset values afterwards.
